// File: rtl/array_argsel_tree.sv
// Purpose : N-channel saturating event counters with a pipelined min/max argument-select tree.
// Latency : counter state after edge t is reported on sel_* after edge t+$clog2(N).
// Backpr. : none; one result per clock, sel_vld marks tokens not sampled during srst.
// Ports   : clk/rst_n (async active-low), srst (sync clear), ce/id (increment),
//           clr_en/clr_id (single clear), mode (0=min,1=max),
//           sel_id/sel_val/sel_vld (winner), sat (sticky per-channel saturation).
module array_argsel_tree #(
  parameter  int N   = 8,
  parameter  int W   = 12,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           srst,
  input  logic           ce,
  input  logic [IDW-1:0] id,
  input  logic           clr_en,
  input  logic [IDW-1:0] clr_id,
  input  logic           mode,
  output logic [IDW-1:0] sel_id,
  output logic [W-1:0]   sel_val,
  output logic           sel_vld,
  output logic [N-1:0]   sat
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0]   cnt_q [N];
  logic [W-1:0]   cnt_d [N];
  logic [N-1:0]   sat_q, sat_d;

  // Comparator tree stored as a heap: node n has children 2n+1 and 2n+2.
  // Children at index >= N-1 are the leaves, i.e. the live counters.
  logic [IDW-1:0] nidx_q  [N-1];
  logic [IDW-1:0] nidx_d  [N-1];
  logic [W-1:0]   nval_q  [N-1];
  logic [W-1:0]   nval_d  [N-1];
  logic           nmode_q [N-1];
  logic           nmode_d [N-1];
  logic [IDW-1:0] vld_q;

  // Counter update: srst beats everything, a clear beats an increment of the same channel.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (srst) begin
      for (int k = 0; k < N; k++) cnt_d[k] = '0;
      sat_d = '0;
    end else begin
      if (ce && !(clr_en && (id == clr_id))) begin
        if (cnt_q[id] == '1) sat_d[id] = 1'b1;
        else                 cnt_d[id] = cnt_q[id] + ONE;
      end
      if (clr_en) begin
        cnt_d[clr_id] = '0;
        sat_d[clr_id] = 1'b0;
      end
    end
  end

  for (genvar n = 0; n < N - 1; n++) begin : g_node
    logic [IDW-1:0] l_idx, r_idx;
    logic [W-1:0]   l_val, r_val;
    logic           tok_mode;
    logic           r_win;

    if (2 * n + 1 >= N - 1) begin : g_leaf
      localparam int LC = 2 * n + 1 - (N - 1);
      assign l_idx    = IDW'(LC);
      assign r_idx    = IDW'(LC + 1);
      assign l_val    = cnt_q[LC];
      assign r_val    = cnt_q[LC + 1];
      assign tok_mode = mode;
    end else begin : g_inner
      assign l_idx    = nidx_q[2 * n + 1];
      assign r_idx    = nidx_q[2 * n + 2];
      assign l_val    = nval_q[2 * n + 1];
      assign r_val    = nval_q[2 * n + 2];
      // Sibling tokens entered the tree together, so they share one mode.
      assign tok_mode = nmode_q[2 * n + 1];
    end

    // Strict compare: on a tie the left (lower-index) token is kept.
    assign r_win      = tok_mode ? (r_val > l_val) : (r_val < l_val);
    assign nidx_d[n]  = r_win ? r_idx : l_idx;
    assign nval_d[n]  = r_win ? r_val : l_val;
    assign nmode_d[n] = tok_mode;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) cnt_q[k] <= '0;
      sat_q <= '0;
      for (int n = 0; n < N - 1; n++) begin
        nidx_q[n]  <= '0;
        nval_q[n]  <= '0;
        nmode_q[n] <= 1'b0;
      end
      vld_q <= '0;
    end else begin
      for (int k = 0; k < N; k++) cnt_q[k] <= cnt_d[k];
      sat_q <= sat_d;
      for (int n = 0; n < N - 1; n++) begin
        nidx_q[n]  <= nidx_d[n];
        nval_q[n]  <= nval_d[n];
        nmode_q[n] <= nmode_d[n];
      end
      // Valid travels alongside the tree; tokens sampled during srst come out invalid.
      vld_q <= (vld_q << 1) | IDW'(!srst);
    end
  end

  assign sel_id  = nidx_q[0];
  assign sel_val = nval_q[0];
  assign sel_vld = vld_q[IDW-1];
  assign sat     = sat_q;

endmodule

// File: tb/tb_array_argsel_tree.sv
module tb_array_argsel_tree;

  localparam int N = 8;
  localparam int W = 4;
  localparam int L = 3;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         srst, ce, clr_en, mode;
  logic [2:0]   id, clr_id;
  logic [2:0]   sel_id;
  logic [W-1:0] sel_val;
  logic         sel_vld;
  logic [N-1:0] sat;

  array_argsel_tree #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .srst(srst), .ce(ce), .id(id),
    .clr_en(clr_en), .clr_id(clr_id), .mode(mode),
    .sel_id(sel_id), .sel_val(sel_val), .sel_vld(sel_vld), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   id;
    logic [W-1:0] val;
    logic         vld;
  } tok_t;

  int        mcnt [N];
  bit  [N-1:0] msat;
  tok_t      hist [$];
  int        nchecks = 0;
  int        nerr    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) mcnt[k] = 0;
    msat = '0;
    hist.delete();
    for (int k = 0; k < L; k++) hist.push_back('0);
  endtask

  // One clock edge of the reference: pick the winner from the pre-edge counts,
  // push it into an L-deep delay line, then apply the counter rules.
  task automatic model_edge();
    int   best;
    tok_t t;
    best = 0;
    for (int k = 1; k < N; k++)
      if (mode ? (mcnt[k] > mcnt[best]) : (mcnt[k] < mcnt[best])) best = k;
    t.id  = 3'(best);
    t.val = W'(mcnt[best]);
    t.vld = !srst;
    hist.push_back(t);
    void'(hist.pop_front());
    if (srst) begin
      for (int k = 0; k < N; k++) mcnt[k] = 0;
      msat = '0;
    end else begin
      if (ce && !(clr_en && id == clr_id)) begin
        if (mcnt[id] == MAXV) msat[id] = 1'b1;
        else                  mcnt[id] = mcnt[id] + 1;
      end
      if (clr_en) begin
        mcnt[clr_id] = 0;
        msat[clr_id] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("sel_vld", 32'(sel_vld), 32'(hist[0].vld));
    chk("sel_id",  32'(sel_id),  32'(hist[0].id));
    chk("sel_val", 32'(sel_val), 32'(hist[0].val));
    chk("sat",     32'(sat),     32'(msat));
  endtask

  task automatic step(input bit s, input bit c, input int i, input bit ce_clr,
                      input int ci, input bit m);
    srst   = s;
    ce     = c;
    id     = 3'(i);
    clr_en = ce_clr;
    clr_id = 3'(ci);
    mode   = m;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input bit m, input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, m);
  endtask

  task automatic inc(input int ch, input int n);
    for (int k = 0; k < n; k++) step(0, 1, ch, 0, 0, 0);
  endtask

  int seed_dummy;

  initial begin
    rst_n = 1'b0; srst = 1'b0; ce = 1'b0; clr_en = 1'b0; mode = 1'b0;
    id = '0; clr_id = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 32'(sel_vld), 32'd0);
    chk("rst_id",  32'(sel_id),  32'd0);
    chk("rst_val", 32'(sel_val), 32'd0);
    chk("rst_sat", 32'(sat),     32'd0);

    // Reset release: valid rises on the third edge
    rst_n = 1'b1;
    idle(0, 2);
    chk("vld_pre_rise", 32'(sel_vld), 32'd0);
    idle(0, 1);
    chk("vld_rise", 32'(sel_vld), 32'd1);
    chk("vld_rise_id", 32'(sel_id), 32'd0);

    // Channels 0..6 once each: channel 7 is the unique minimum
    for (int k = 0; k < 7; k++) inc(k, 1);
    idle(0, 3);
    chk("min_id",  32'(sel_id),  32'd7);
    chk("min_val", 32'(sel_val), 32'd0);
    inc(7, 2);
    idle(1, 3);
    chk("max_id",  32'(sel_id),  32'd7);
    chk("max_val", 32'(sel_val), 32'd2);

    // srst pulse: valid drops for exactly one cycle, aligned with the masked token
    step(1, 1, 3, 0, 0, 1);
    chk("srst_sat", 32'(sat), 32'd0);
    idle(1, 1);
    chk("srst_vld_hold", 32'(sel_vld), 32'd1);
    idle(1, 1);
    chk("srst_vld_drop", 32'(sel_vld), 32'd0);
    idle(1, 1);
    chk("srst_vld_back", 32'(sel_vld), 32'd1);
    chk("srst_cleared",  32'(sel_val), 32'd0);

    // Saturation on channel 2
    inc(2, 15);
    chk("sat_not_at_max", 32'(sat[2]), 32'd0);
    inc(2, 1);
    chk("sat_set", 32'(sat[2]), 32'd1);
    inc(2, 1);
    idle(1, 3);
    chk("sat_id",  32'(sel_id),  32'd2);
    chk("sat_val", 32'(sel_val), 32'd15);
    step(0, 0, 0, 1, 2, 1);
    chk("sat_clr", 32'(sat[2]), 32'd0);
    idle(1, 3);
    chk("clr_val", 32'(sel_val), 32'd0);

    // Clear versus increment on the same cycle
    inc(3, 5);
    step(0, 1, 3, 1, 3, 1);
    step(0, 1, 1, 1, 3, 1);
    idle(1, 3);
    chk("ce_clr_id",  32'(sel_id),  32'd1);
    chk("ce_clr_val", 32'(sel_val), 32'd1);

    // Mode toggling with counts {4,9,2,9,5,5,5,5}
    step(1, 0, 0, 0, 0, 0);
    inc(0, 4); inc(1, 9); inc(2, 2); inc(3, 9);
    for (int k = 4; k < 8; k++) inc(k, 5);
    idle(0, 2);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("tog0_id",  32'(sel_id),  32'd2);
    chk("tog0_val", 32'(sel_val), 32'd2);
    idle(0, 1);
    chk("tog1_id",  32'(sel_id),  32'd1);
    chk("tog1_val", 32'(sel_val), 32'd9);
    idle(0, 1);
    chk("tog2_id",  32'(sel_id),  32'd2);
    chk("tog2_val", 32'(sel_val), 32'd2);

    // Randomized traffic against the reference
    for (int n = 0; n < 400; n++)
      step(($urandom_range(0, 31) == 0), 1'($urandom), $urandom_range(0, 7),
           ($urandom_range(0, 3) == 0), $urandom_range(0, 7), 1'($urandom));

    // Asynchronous reset in mid-stream
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(sel_vld), 32'd0);
    chk("arst_id",  32'(sel_id),  32'd0);
    chk("arst_val", 32'(sel_val), 32'd0);
    chk("arst_sat", 32'(sat),     32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 100; n++)
      step(($urandom_range(0, 31) == 0), 1'($urandom), $urandom_range(0, 7),
           ($urandom_range(0, 3) == 0), $urandom_range(0, 7), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
